// File: rtl/proc_seq.sv
// Packet sequencer: pops a header, walks the non-bypassed stages through a
// start/ready handshake, then commits, drops or times out the packet.
module proc_seq #(
    parameter int  NUM_STAGES = 3,
    parameter int  TIMEOUT_W  = 16,
    parameter int  CNT_W      = 32,
    localparam int STG_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_empty_i,
    output logic                  in_rd_o,
    input  logic                  out_empty_i,
    output logic                  out_wr_o,
    input  logic                  mod_busy_i,
    output logic                  idle_o,
    output logic [NUM_STAGES-1:0] stg_start_o,
    input  logic [NUM_STAGES-1:0] stg_ready_i,
    input  logic [NUM_STAGES-1:0] stg_drop_i,
    input  logic [NUM_STAGES-1:0] stg_bypass_i,
    input  logic [TIMEOUT_W-1:0]  timeout_lim_i,
    output logic [STG_W-1:0]      cur_stage_o,
    output logic                  err_o,
    output logic [STG_W-1:0]      err_stage_o,
    output logic [CNT_W-1:0]      pkt_cnt_o,
    output logic [CNT_W-1:0]      drop_cnt_o,
    output logic [CNT_W-1:0]      timeout_cnt_o
);

    typedef enum logic [1:0] {S_FREE, S_WAIT, S_HOLD, S_LATCH} state_t;

    state_t                r_state, w_state_nxt;
    logic [NUM_STAGES-1:0] r_mask, w_mask_nxt;
    logic [NUM_STAGES-1:0] r_start, w_start_nxt;
    logic [STG_W-1:0]      r_cur, w_cur_nxt;
    logic [STG_W-1:0]      r_err_stage;
    logic [TIMEOUT_W-1:0]  r_timer, w_timer_nxt, w_timer_inc;
    logic                  r_rd, r_wr, r_err;
    logic [CNT_W-1:0]      r_pkt_cnt, r_drop_cnt, r_to_cnt;
    logic                  w_first_vld, w_next_vld;
    logic [STG_W-1:0]      w_first_idx, w_next_idx;
    logic                  w_in_start, w_rdy, w_drp;
    logic                  w_wr_ev, w_drop_ev, w_to_ev;

    // Lowest stage to run at accept, and the next one above the active stage.
    always_comb begin
        w_first_vld = 1'b0;
        w_first_idx = '0;
        w_next_vld  = 1'b0;
        w_next_idx  = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (!w_first_vld && !stg_bypass_i[j]) begin
                w_first_vld = 1'b1;
                w_first_idx = STG_W'(j);
            end
            if (!w_next_vld && !r_mask[j] && (j > int'(r_cur))) begin
                w_next_vld = 1'b1;
                w_next_idx = STG_W'(j);
            end
        end
    end

    // Ready is not trusted while the start pulse is still on the wire.
    assign w_in_start  = |r_start;
    assign w_rdy       = stg_ready_i[r_cur] & ~w_in_start;
    assign w_drp       = stg_drop_i[r_cur];
    assign w_timer_inc = r_timer + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_start_nxt = '0;
        w_cur_nxt   = r_cur;
        w_timer_nxt = r_timer;
        w_wr_ev     = 1'b0;
        w_drop_ev   = 1'b0;
        w_to_ev     = 1'b0;
        case (r_state)
            S_FREE: begin
                if (!in_empty_i && !mod_busy_i) begin
                    w_mask_nxt  = stg_bypass_i;
                    w_timer_nxt = '0;
                    if (w_first_vld) begin
                        w_start_nxt[w_first_idx] = 1'b1;
                        w_cur_nxt   = w_first_idx;
                        w_state_nxt = S_WAIT;
                    end else if (out_empty_i) begin
                        w_wr_ev     = 1'b1;
                        w_state_nxt = S_LATCH;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_WAIT: begin
                if (w_in_start) begin
                    w_timer_nxt = r_timer;
                end else if (w_rdy) begin
                    w_timer_nxt = '0;
                    if (w_drp) begin
                        w_drop_ev   = 1'b1;
                        w_state_nxt = S_LATCH;
                    end else if (w_next_vld) begin
                        w_start_nxt[w_next_idx] = 1'b1;
                        w_cur_nxt = w_next_idx;
                    end else if (out_empty_i) begin
                        w_wr_ev     = 1'b1;
                        w_state_nxt = S_LATCH;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end else if ((timeout_lim_i != '0) && (w_timer_inc == timeout_lim_i)) begin
                    w_to_ev     = 1'b1;
                    w_state_nxt = S_LATCH;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            S_HOLD: begin
                if (out_empty_i) begin
                    w_wr_ev     = 1'b1;
                    w_state_nxt = S_LATCH;
                end
            end
            default: w_state_nxt = S_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_FREE;
            r_mask      <= '0;
            r_start     <= '0;
            r_cur       <= '0;
            r_timer     <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_err       <= 1'b0;
            r_err_stage <= '0;
            r_pkt_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_start <= w_start_nxt;
            r_cur   <= w_cur_nxt;
            r_timer <= w_timer_nxt;
            r_rd    <= w_wr_ev | w_drop_ev | w_to_ev;
            r_wr    <= w_wr_ev;
            r_err   <= w_to_ev;
            if (w_to_ev)
                r_err_stage <= r_cur;
            if (w_wr_ev && (r_pkt_cnt != '1))
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            if (w_drop_ev && (r_drop_cnt != '1))
                r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_to_ev && (r_to_cnt != '1))
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign idle_o        = (r_state == S_FREE);
    assign in_rd_o       = r_rd;
    assign out_wr_o      = r_wr;
    assign err_o         = r_err;
    assign err_stage_o   = r_err_stage;
    assign stg_start_o   = r_start;
    assign cur_stage_o   = r_cur;
    assign pkt_cnt_o     = r_pkt_cnt;
    assign drop_cnt_o    = r_drop_cnt;
    assign timeout_cnt_o = r_to_cnt;

endmodule

// File: tb/tb_proc_seq.sv
// Scoreboard bench for proc_seq: a latency model per packet feeds expected
// starts and completions; a negedge monitor pops and compares them.
module tb_proc_seq;

    localparam int NS  = 3;
    localparam int CMX = 7;

    logic        clk = 1'b0, rst = 1'b0;
    logic        in_empty_i = 1'b1, out_empty_i = 1'b1, mod_busy_i = 1'b0;
    logic [2:0]  stg_ready_i = '0, stg_drop_i = '0, stg_bypass_i = '0;
    logic [7:0]  timeout_lim_i = '0;
    logic        in_rd_o, out_wr_o, idle_o, err_o;
    logic [2:0]  stg_start_o;
    logic [1:0]  cur_stage_o, err_stage_o;
    logic [2:0]  pkt_cnt_o, drop_cnt_o, timeout_cnt_o;

    proc_seq #(.NUM_STAGES(NS), .TIMEOUT_W(8), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_empty_i(in_empty_i), .in_rd_o(in_rd_o),
        .out_empty_i(out_empty_i), .out_wr_o(out_wr_o),
        .mod_busy_i(mod_busy_i), .idle_o(idle_o),
        .stg_start_o(stg_start_o), .stg_ready_i(stg_ready_i),
        .stg_drop_i(stg_drop_i), .stg_bypass_i(stg_bypass_i),
        .timeout_lim_i(timeout_lim_i), .cur_stage_o(cur_stage_o),
        .err_o(err_o), .err_stage_o(err_stage_o),
        .pkt_cnt_o(pkt_cnt_o), .drop_cnt_o(drop_cnt_o), .timeout_cnt_o(timeout_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct { int lat; logic wr; logic err; int stg; logic [2:0] starts; } exp_t;
    typedef struct { int off; int stg; } st_t;
    exp_t pq[$];
    st_t  sq[$];

    int n_chk = 0, n_err = 0;
    int mcyc = 0, t0 = 0;
    int dly[NS];
    int m_pkt = 0, m_drop = 0, m_to = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMX) ? CMX : v + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stage responders: ready arrives dly[s] cycles after the start pulse.
    initial begin
        int due[NS];
        int rc;
        rc = 0;
        for (int s = 0; s < NS; s++) due[s] = -1;
        forever begin
            @(posedge clk);
            #1;
            rc++;
            for (int s = 0; s < NS; s++) begin
                if (stg_start_o[s]) due[s] = (dly[s] > 0) ? rc + dly[s] : -1;
                stg_ready_i[s] = (due[s] == rc);
                if (due[s] == rc) due[s] = -1;
            end
        end
    end

    initial begin
        logic [2:0] seen;
        seen = '0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (rst) begin
                if (stg_start_o != '0) begin
                    if (sq.size() == 0) chk("start_unexp", stg_start_o, 0);
                    else begin
                        st_t e;
                        e = sq.pop_front();
                        chk("start_time", mcyc - t0, e.off);
                        chk("start_stage", stg_start_o, 64'(1) << e.stg);
                        chk("cur_stage", cur_stage_o, e.stg);
                        seen |= stg_start_o;
                    end
                end
                if (out_wr_o && !in_rd_o) chk("wr_without_rd", 1, 0);
                if (err_o && !in_rd_o) chk("err_without_rd", 1, 0);
                if (in_rd_o) begin
                    if (pq.size() == 0) chk("rd_unexp", 1, 0);
                    else begin
                        exp_t e;
                        e = pq.pop_front();
                        chk("rd_latency", mcyc - t0, e.lat);
                        chk("out_wr", out_wr_o, e.wr);
                        chk("err", err_o, e.err);
                        if (e.err) chk("err_stage", err_stage_o, e.stg);
                        chk("started_set", seen, e.starts);
                    end
                    seen = '0;
                end
                if (idle_o && !in_empty_i && !mod_busy_i) begin
                    t0   = mcyc;
                    seen = '0;
                end
            end
        end
    end

    task automatic wait_idle();
        int w;
        w = 0;
        while (!idle_o && w < 60) begin
            step();
            w++;
        end
        if (!idle_o) chk("idle_wait", idle_o, 1);
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_pkt"}, pkt_cnt_o, m_pkt);
        chk({tag, "_drop"}, drop_cnt_o, m_drop);
        chk({tag, "_to"}, timeout_cnt_o, m_to);
    endtask

    // h: out_empty_i stays low from accept through h cycles past the last ready.
    task automatic send_pkt(input logic [2:0] byp, input int d0, input int d1, input int d2,
                            input logic [2:0] drp, input int lim, input int h, input bit busy_mid);
        int   dl[NS];
        int   t, lr, rd, kind;
        exp_t e;
        dl[0] = d0; dl[1] = d1; dl[2] = d2;
        t = 1; lr = 0; kind = 0; rd = 0;
        e.wr = 1'b0; e.err = 1'b0; e.stg = 0; e.starts = '0;
        for (int s = 0; s < NS; s++) begin
            if (!byp[s] && kind == 0) begin
                st_t st;
                st.off = t; st.stg = s;
                sq.push_back(st);
                e.starts[s] = 1'b1;
                if (lim != 0 && (dl[s] == 0 || dl[s] > lim)) begin
                    kind = 2; rd = t + lim + 1; e.stg = s;
                end else if (drp[s]) begin
                    kind = 1; rd = t + dl[s] + 1;
                end else begin
                    lr = t + dl[s];
                    t  = t + dl[s] + 1;
                end
            end
        end
        if (kind == 0) rd = (h == 0) ? lr + 1 : lr + h + 2;
        e.lat = rd;
        e.wr  = (kind == 0);
        e.err = (kind == 2);
        pq.push_back(e);
        if (kind == 0) m_pkt = sat(m_pkt);
        if (kind == 1) m_drop = sat(m_drop);
        if (kind == 2) m_to = sat(m_to);

        wait_idle();
        for (int s = 0; s < NS; s++) dly[s] = dl[s];
        stg_drop_i    = drp;
        stg_bypass_i  = byp;
        timeout_lim_i = 8'(lim);
        out_empty_i   = (h == 0);
        in_empty_i    = 1'b0;
        for (int k = 1; k <= rd + 1; k++) begin
            step();
            if (k == 1) begin
                in_empty_i   = 1'b1;
                stg_bypass_i = 3'($urandom_range(0, 7));
                if (busy_mid) mod_busy_i = 1'b1;
            end
            if (h > 0 && k == lr + h + 1) out_empty_i = 1'b1;
        end
        chk("free_after", idle_o, 1);
        chk("sb_drain", pq.size() + sq.size(), 0);
        pq.delete();
        sq.delete();
        chk_cnts("cnt");
        mod_busy_i  = 1'b0;
        out_empty_i = 1'b1;
        stg_drop_i  = '0;
    endtask

    initial begin
        for (int s = 0; s < NS; s++) dly[s] = 1;
        rst = 1'b0;
        step();
        step();
        chk("rst_idle", idle_o, 1);
        chk("rst_rd", in_rd_o, 0);
        chk("rst_wr", out_wr_o, 0);
        chk("rst_start", stg_start_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_cur", cur_stage_o, 0);
        chk("rst_err_stage", err_stage_o, 0);
        chk_cnts("rst");
        rst = 1'b1;
        step();

        send_pkt(3'b000, 1, 1, 1, 3'b000, 0, 0, 0);   // basic
        send_pkt(3'b010, 1, 1, 1, 3'b000, 0, 0, 0);   // bypass middle
        send_pkt(3'b111, 1, 1, 1, 3'b000, 0, 0, 0);   // all bypassed
        send_pkt(3'b000, 1, 1, 1, 3'b010, 0, 0, 0);   // drop at stage 1
        send_pkt(3'b000, 0, 1, 1, 3'b000, 4, 0, 0);   // timeout at stage 0
        send_pkt(3'b000, 4, 1, 1, 3'b000, 4, 0, 0);   // ready in last watchdog cycle
        send_pkt(3'b000, 1, 1, 1, 3'b000, 0, 10, 0);  // backpressure
        send_pkt(3'b111, 1, 1, 1, 3'b000, 0, 3, 0);   // all bypassed, backpressure
        send_pkt(3'b000, 2, 1, 3, 3'b000, 0, 0, 1);   // quiesce raised mid-flight
        send_pkt(3'b001, 1, 0, 1, 3'b000, 3, 0, 0);   // timeout at stage 1

        // Quiesce: input pending but reconfiguration blocks acceptance.
        wait_idle();
        mod_busy_i = 1'b1;
        in_empty_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i % 2 == 1) chk("quiesce_idle", idle_o, 1);
        end
        in_empty_i = 1'b1;
        mod_busy_i = 1'b0;
        step();

        // Reset while stage 0 is outstanding: the packet must not be popped.
        wait_idle();
        dly[0] = 0; dly[1] = 1; dly[2] = 1;
        timeout_lim_i = '0;
        stg_bypass_i  = '0;
        begin
            st_t st;
            st.off = 1; st.stg = 0;
            sq.push_back(st);
        end
        in_empty_i = 1'b0;
        step();
        in_empty_i = 1'b1;
        repeat (4) step();
        chk("mid_wait_busy", idle_o, 0);
        rst = 1'b0;
        step();
        chk("mrst_idle", idle_o, 1);
        chk("mrst_rd", in_rd_o, 0);
        chk("mrst_wr", out_wr_o, 0);
        chk("mrst_start", stg_start_o, 0);
        chk("mrst_err", err_o, 0);
        chk("mrst_cur", cur_stage_o, 0);
        chk("mrst_err_stage", err_stage_o, 0);
        m_pkt = 0; m_drop = 0; m_to = 0;
        chk_cnts("mrst");
        rst = 1'b1;
        repeat (3) step();
        chk("mrst_sb", pq.size() + sq.size(), 0);
        sq.delete();

        // Mixed traffic, enough writes to drive the counters into saturation.
        for (int n = 0; n < 14; n++) begin
            logic [2:0] byp, drp;
            int lim, h;
            byp = 3'($urandom_range(0, 7));
            drp = ($urandom_range(0, 4) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            lim = ($urandom_range(0, 2) == 0) ? 4 : 0;
            h   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            send_pkt(byp, $urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 5),
                     drp, lim, h, 1'b0);
        end
        for (int n = 0; n < 8; n++) send_pkt(3'b000, 1, 2, 1, 3'b000, 0, 0, 0);
        chk("pkt_saturated", pkt_cnt_o, CMX);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish before bound");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/proc_seq.md
# proc_seq

Parametrised packet-processing sequencer, the next-generation controller of the processor core. It pops one packet header from the input buffer and drives a chain of `NUM_STAGES` processing stages in order, each through a start/ready handshake. Stages are typically parser, one or more matchers and executors. It then commits the packet to the output buffer or drops it. Beyond plain sequencing, it adds:
- per-packet stage bypass;
- stage-requested drop;
- a per-stage watchdog timeout;
- a reconfiguration quiesce input;
- saturating statistics counters.

## Interface
Parameters:
- `NUM_STAGES`, default 3: number of sequenced stages (≥1).
- `TIMEOUT_W`, default 16: watchdog timer width.
- `CNT_W`, default 32: statistics counter width.
- `STG_W` (localparam) = max(1, clog2(`NUM_STAGES`)).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_empty_i`  in  1  input buffer empty.
- `in_rd_o`  out  1  one-cycle pop of input buffer.
- `out_empty_i`  in  1  output slot free; write allowed when high.
- `out_wr_o`  out  1  one-cycle push to output buffer.
- `mod_busy_i`  in  1  reconfiguration in progress; blocks new packets.
- `idle_o`  out  1  high while in FREE.
- `stg_start_o`  out  `NUM_STAGES`  one-hot, one-cycle start pulse.
- `stg_ready_i`  in  `NUM_STAGES`  stage done.
- `stg_drop_i`  in  `NUM_STAGES`  stage requests drop; qualified by its ready.
- `stg_bypass_i`  in  `NUM_STAGES`  skip mask, sampled at packet accept.
- `timeout_lim_i`  in  `TIMEOUT_W`  watchdog limit in cycles; 0 disables.
- `cur_stage_o`  out  `STG_W`  index of active stage.
- `err_o`  out  1  one-cycle timeout pulse.
- `err_stage_o`  out  `STG_W`  stage index of the last timeout.
- `pkt_cnt_o`, `drop_cnt_o`, `timeout_cnt_o`  out  `CNT_W` each  forwarded, dropped and timed-out packet counts.

## Operation
- FSM states: FREE, WAIT, HOLD, LATCH.
- **FREE** (`idle_o`=1):
  - Accepts a packet when `in_empty_i`=0 and `mod_busy_i`=0; otherwise stays in FREE.
  - On accept, latches `stg_bypass_i` into an internal mask and selects the lowest non-bypassed stage k.
  - Sets `stg_start_o[k]`, `cur_stage_o`=k, clears the timer, goes to WAIT.
  - If every stage is bypassed: goes to LATCH (write) when `out_empty_i`=1, else to HOLD.
- **WAIT**:
  - `stg_start_o` deasserts after its single cycle. `stg_ready_i` is ignored in the cycle the start pulse is high.
  - On `stg_ready_i[k]` with `stg_drop_i[k]`=1: goes to LATCH as a drop.
  - On `stg_ready_i[k]` with `stg_drop_i[k]`=0: pulses start on the next higher non-bypassed stage and stays in WAIT with the timer cleared.
  - If k was the last non-bypassed stage: goes to LATCH (write) when `out_empty_i`=1, else to HOLD.
  - Ready bits of non-active stages are ignored.
- **Watchdog**: each WAIT cycle after the start cycle without ready increments the timer. When timer+1 == `timeout_lim_i` (nonzero), goes to LATCH as a timeout drop and sets `err_stage_o`=k. Ready and timeout in the same cycle: ready wins.
- **HOLD**: waits for `out_empty_i`=1, then goes to LATCH (write). No timeout applies in HOLD.
- **LATCH entry** (registered):
  - Write: `in_rd_o`=1, `out_wr_o`=1, `pkt_cnt_o`+1.
  - Drop: `in_rd_o`=1, `out_wr_o`=0, `drop_cnt_o`+1.
  - Timeout: as drop, plus `err_o`=1 and `timeout_cnt_o`+1.
- **LATCH**: clears `in_rd_o`, `out_wr_o`, `err_o`; next state is FREE.
- Counters saturate at all-ones.
- `mod_busy_i` only gates acceptance in FREE. A packet already in flight completes normally.

## Timing
- Reset values (`rst`=0 at a clock edge): state FREE; `in_rd_o`, `out_wr_o`, `stg_start_o`, `err_o` = 0; `cur_stage_o`, `err_stage_o` = 0; all counters 0; timer 0; `idle_o`=1.
- Reset mid-packet aborts the packet without popping it, so the packet stays in the input buffer.
- Best-case latency, N active stages, each ready at first opportunity, output free:
  - accept seen at T0;
  - `stg_start_o[s]` high at T(2s+1), for s = 0 .. N-1 counting active stages only;
  - last ready at T(2N);
  - `in_rd_o`/`out_wr_o` high at T(2N+1);
  - FREE again at T(2N+2).
- The earliest next accept is therefore T(2N+2).
- `in_rd_o` and `out_wr_o` are always simultaneous single-cycle pulses on the write path. The drop path never asserts `out_wr_o`.
- `stg_bypass_i` changes after accept do not affect the in-flight packet.

## Test plan
- **Basic**: NUM_STAGES=3, no bypass, every ready one cycle after its start, `out_empty_i`=1. Required: starts at T1, T3, T5; rd/wr at T7; `pkt_cnt_o`=1.
- **Bypass**: mask 3'b010. Required: only stages 0 and 2 start; rd/wr at T5. Mask 3'b111: rd/wr at T1, no starts.
- **Drop**: stage 1 ready with drop=1. Required: `in_rd_o`=1 and `out_wr_o`=0 for one cycle; stage 2 never started; `drop_cnt_o`=1.
- **Timeout**: `timeout_lim_i`=4, stage 0 never ready. Required: `err_o` with `in_rd_o` 4 WAIT cycles after the start cycle; `err_stage_o`=0; `timeout_cnt_o`=1. Repeat with ready in the 4th cycle: required normal completion.
- **Backpressure**: `out_empty_i`=0 for 10 cycles after the last ready. Required: HOLD for those 10 cycles, then rd/wr in the cycle after `out_empty_i` rises.
- **Quiesce and reset**: `mod_busy_i`=1 with input non-empty. Required: no start, `idle_o`=1. Reset asserted during WAIT. Required: all outputs return to reset values and `in_rd_o` never pulses.
